// File: rtl/oci_dct_packer_if.sv
// Trace-symbol input and DCT buffer output bundle for the OCI DCT packer.
// The master drives symbols and the end-of-test request and consumes buffers; the slave is the packer.
interface oci_dct_packer_if #(
  parameter int unsigned SYM_W = 3,
  parameter int unsigned SYMS  = 10
);
  localparam int unsigned BUF_W = SYM_W * SYMS;
  localparam int unsigned CNT_W = $clog2(SYMS + 1);

  logic [SYM_W-1:0] sym_data;
  logic             sym_valid;
  logic             sym_ready;
  logic             test_ending;
  logic [BUF_W-1:0] dct_buffer;
  logic [CNT_W-1:0] dct_count;
  logic             dct_valid;
  logic             dct_ready;
  logic             test_has_ended;

  modport master (
    output sym_data, sym_valid, test_ending, dct_ready,
    input  sym_ready, dct_buffer, dct_count, dct_valid, test_has_ended
  );

  modport slave (
    input  sym_data, sym_valid, test_ending, dct_ready,
    output sym_ready, dct_buffer, dct_count, dct_valid, test_has_ended
  );
endinterface

// File: rtl/oci_dct_packer.sv
// Packs 3-bit OCI data-trace symbols into a 30-bit DCT buffer and offers it downstream,
// flushing partial buffers on idle timeout or end-of-test.
module oci_dct_packer #(
  parameter int unsigned SYM_W         = 3,
  parameter int unsigned SYMS          = 10,
  parameter int unsigned FLUSH_TIMEOUT = 64
) (
  input logic             clk,
  input logic             reset,
  oci_dct_packer_if.slave bus
);
  localparam int unsigned BUF_W = SYM_W * SYMS;
  localparam int unsigned CNT_W = $clog2(SYMS + 1);
  localparam int unsigned TMO_W = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = (FLUSH_TIMEOUT == 0) ? '0 : TMO_W'(FLUSH_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SYMS);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [BUF_W-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TMO_W-1:0] idle_q;
  logic             valid_q;
  logic             ended_q;
  logic             end_pending_q;

  logic             accept;
  logic             end_req;
  logic [BUF_W-1:0] data_d;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    accept  = bus.sym_valid && (state_q == FILL);
    end_req = end_pending_q || bus.test_ending;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (accept) begin
      data_d = {data_q[BUF_W-SYM_W-1:0], bus.sym_data};
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  // In FILL the current accept is folded in before any full/flush/timeout decision,
  // so a symbol arriving together with test_ending lands in the final buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FILL;
      data_q        <= '0;
      cnt_q         <= '0;
      idle_q        <= '0;
      valid_q       <= 1'b0;
      ended_q       <= 1'b0;
      end_pending_q <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          data_q <= data_d;
          cnt_q  <= cnt_d;
          if (bus.test_ending) end_pending_q <= 1'b1;
          if (cnt_d == CNT_FULL) begin
            state_q <= EMIT;
            valid_q <= 1'b1;
            idle_q  <= '0;
          end else if (end_req) begin
            idle_q <= '0;
            if (cnt_d != '0) begin
              state_q <= EMIT;
              valid_q <= 1'b1;
            end else begin
              state_q <= DONE;
              ended_q <= 1'b1;
            end
          end else if (accept || (cnt_q == '0)) begin
            idle_q <= '0;
          end else if (FLUSH_TIMEOUT != 0) begin
            if (idle_q == TMO_LAST) begin
              state_q <= EMIT;
              valid_q <= 1'b1;
              idle_q  <= '0;
            end else begin
              idle_q <= idle_q + TMO_W'(1);
            end
          end
        end
        EMIT: begin
          if (bus.test_ending) end_pending_q <= 1'b1;
          if (bus.dct_ready) begin
            data_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            if (end_pending_q) begin
              state_q <= DONE;
              ended_q <= 1'b1;
            end else begin
              state_q <= FILL;
            end
          end
        end
        DONE: begin
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= FILL;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sym_ready      = (state_q == FILL);
  assign bus.dct_buffer     = data_q;
  assign bus.dct_count      = cnt_q;
  assign bus.dct_valid      = valid_q;
  assign bus.test_has_ended = ended_q;
endmodule
